// File: rtl/usb_pkg.sv
// Shared USB buffer-side definitions: FSM encodings, buffer widths and the length clamp,
// used by both the OUT-buffer reader and the IN-buffer writer.
package usb_pkg;

   localparam int ADDR_W          = 9;
   localparam int LEN_W           = 10;
   localparam int MAX_LEN_DEFAULT = 512;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARM       = 3'd1,
      ARM_WAIT  = 3'd2,
      WAIT_DATA = 3'd3,
      READ      = 3'd4,
      LAT       = 3'd5,
      PRESENT   = 3'd6
   } buf_state_e;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                  input logic [LEN_W-1:0] max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // NOTE: sequential state uses non-blocking assignments so both flops sample the old values.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/usb_out_reader.sv
// Drains packets from the USB OUT buffer into a valid/ready byte stream, one byte
// per READ/LAT/PRESENT round trip, re-arming the buffer after every packet.
module usb_out_reader
   import usb_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
   input  logic              clk_50,
   input  logic              reset,
   input  logic              usb_configured,
   input  logic              buf_out_hasdata,
   input  logic [LEN_W-1:0]  buf_out_len,
   output logic              buf_out_arm,
   input  logic              buf_out_arm_ack,
   output logic [ADDR_W-1:0] buf_out_addr,
   input  logic [7:0]        buf_out_q,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [15:0]       pkt_count
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   logic usb_configured_s;
   logic buf_out_hasdata_s;
   logic buf_out_arm_ack_s;

   sync_2ff u_sync_cfg  (.clk(clk_50), .reset(reset), .d_i(usb_configured),  .q_o(usb_configured_s));
   sync_2ff u_sync_data (.clk(clk_50), .reset(reset), .d_i(buf_out_hasdata), .q_o(buf_out_hasdata_s));
   sync_2ff u_sync_ack  (.clk(clk_50), .reset(reset), .d_i(buf_out_arm_ack), .q_o(buf_out_arm_ack_s));

   buf_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [LEN_W-1:0]  len_q,   len_d;
   logic [7:0]        data_q,  data_d;
   logic              last_q,  last_d;
   logic [15:0]       pkt_q,   pkt_d;
   logic [LEN_W-1:0]  len_clamped;

   assign len_clamped = clamp_len(buf_out_len, LEN_MAX);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      data_d  = data_q;
      last_d  = last_q;
      pkt_d   = pkt_q;

      // Losing configuration abandons whatever is in flight, including a pending handshake.
      if (!usb_configured_s && state_q != IDLE) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (usb_configured_s) state_d = ARM;
            end
            ARM: begin
               if (buf_out_arm_ack_s) state_d = ARM_WAIT;
            end
            ARM_WAIT: begin
               if (!buf_out_arm_ack_s) state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
               if (buf_out_hasdata_s) begin
                  len_d  = len_clamped;
                  addr_d = '0;
                  if (len_clamped == '0) begin
                     pkt_d   = pkt_q + 16'd1;
                     state_d = ARM;
                  end else begin
                     state_d = READ;
                  end
               end
            end
            READ: begin
               state_d = LAT;
            end
            LAT: begin
               data_d  = buf_out_q;
               last_d  = ({1'b0, addr_q} == len_q - 1'b1);
               state_d = PRESENT;
            end
            PRESENT: begin
               if (out_ready) begin
                  if (last_q) begin
                     pkt_d   = pkt_q + 16'd1;
                     state_d = ARM;
                  end else begin
                     addr_d  = addr_q + 1'b1;
                     state_d = READ;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         pkt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         data_q  <= data_d;
         last_q  <= last_d;
         pkt_q   <= pkt_d;
      end
   end

   // Gating with the synchronized status drops out_valid in the same cycle configuration is lost.
   assign out_valid    = (state_q == PRESENT) && usb_configured_s;
   assign buf_out_arm  = (state_q == ARM);
   assign buf_out_addr = addr_q;
   assign out_data     = data_q;
   assign out_last     = last_q;
   assign pkt_count    = pkt_q;

endmodule

// File: tb/tb_usb_out_reader.sv
// Directed bench for usb_out_reader: a behavioural OUT buffer with a one-cycle read
// latency and a host that acks arm requests and frees the buffer when armed.
module tb_usb_out_reader;
   import usb_pkg::*;

   logic        clk_50 = 1'b0;
   logic        reset;
   logic        usb_configured;
   logic        buf_out_hasdata;
   logic [9:0]  buf_out_len;
   logic        buf_out_arm;
   logic        buf_out_arm_ack;
   logic [8:0]  buf_out_addr;
   logic [7:0]  buf_out_q;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [15:0] pkt_count;

   logic [7:0]  mem [0:511];
   int          cyc = 0;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   logic [7:0]  got_data [$];
   logic        got_last [$];
   logic [8:0]  got_addr [$];
   int          got_cyc  [$];

   usb_out_reader #(.MAX_LEN(512)) dut (
      .clk_50          (clk_50),
      .reset           (reset),
      .usb_configured  (usb_configured),
      .buf_out_hasdata (buf_out_hasdata),
      .buf_out_len     (buf_out_len),
      .buf_out_arm     (buf_out_arm),
      .buf_out_arm_ack (buf_out_arm_ack),
      .buf_out_addr    (buf_out_addr),
      .buf_out_q       (buf_out_q),
      .out_data        (out_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_last        (out_last),
      .pkt_count       (pkt_count)
   );

   always #10 clk_50 = ~clk_50;

   always @(posedge clk_50) begin
      cyc       <= cyc + 1;
      buf_out_q <= mem[buf_out_addr];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // One cycle; the host side answers arm with ack and frees the buffer while armed.
   task automatic tick();
      @(negedge clk_50);
      buf_out_arm_ack = buf_out_arm;
      if (buf_out_arm) buf_out_hasdata = 1'b0;
   endtask

   task automatic start_packet(input int len);
      int n;
      n = 0;
      while (buf_out_arm !== 1'b1 && n < 60) begin tick(); n++; end
      total_cnt++;
      if (buf_out_arm !== 1'b1) $display("FAIL arm_request: buf_out_arm=%b required 1", buf_out_arm);
      else pass_cnt++;
      n = 0;
      while (buf_out_arm !== 1'b0 && n < 60) begin tick(); n++; end
      total_cnt++;
      if (buf_out_arm !== 1'b0) $display("FAIL arm_release: buf_out_arm=%b required 0", buf_out_arm);
      else pass_cnt++;
      buf_out_len     = 10'(len);
      buf_out_hasdata = 1'b1;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 60) begin tick(); n++; end
      total_cnt++;
      if (out_valid !== 1'b1) $display("FAIL %s: out_valid=%b required 1", name, out_valid);
      else pass_cnt++;
   endtask

   // Accepts bytes until out_last; optionally withholds out_ready for stall_len cycles on byte stall_idx.
   task automatic collect(input int max_cycles, input int stall_idx, input int stall_len);
      int n, stall_n;
      logic [7:0] held;
      bit done;
      got_data.delete(); got_last.delete(); got_addr.delete(); got_cyc.delete();
      n = 0; stall_n = 0; done = 1'b0; held = '0;
      while (!done && n < max_cycles) begin
         tick(); n++;
         out_ready = 1'b1;
         if (stall_n > 0 && stall_n < stall_len) begin
            out_ready = 1'b0;
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== held)
               $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, held);
            else pass_cnt++;
            stall_n++;
         end else if (out_valid === 1'b1) begin
            if (got_data.size() == stall_idx && stall_n == 0 && stall_len > 0) begin
               out_ready = 1'b0;
               held      = out_data;
               stall_n   = 1;
            end else begin
               got_data.push_back(out_data);
               got_last.push_back(out_last);
               got_addr.push_back(buf_out_addr);
               got_cyc.push_back(cyc);
               if (out_last === 1'b1) done = 1'b1;
            end
         end
      end
      total_cnt++;
      if (!done) $display("FAIL collect_timeout: %0d bytes seen, required out_last within %0d cycles", got_data.size(), max_cycles);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b1; usb_configured = 1'b0; buf_out_hasdata = 1'b0; buf_out_len = '0;
      buf_out_arm_ack = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 512; i++) mem[i] = '0;
      repeat (3) tick();
      total_cnt++;
      if ({buf_out_arm, out_valid, out_last} !== 3'b000)
         $display("FAIL reset_ctrl: arm/valid/last=%b required 000", {buf_out_arm, out_valid, out_last});
      else pass_cnt++;
      total_cnt++;
      if (buf_out_addr !== 9'd0 || out_data !== 8'd0 || pkt_count !== 16'd0)
         $display("FAIL reset_regs: addr=%h data=%h pkt=%h required 0", buf_out_addr, out_data, pkt_count);
      else pass_cnt++;
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin tick(); if (buf_out_arm === 1'b1) n++; end
      total_cnt++;
      if (n != 0) $display("FAIL unconfigured_idle: arm high %0d cycles, required 0", n);
      else pass_cnt++;
      usb_configured = 1'b1;
   endtask

   task automatic test_basic();
      logic [7:0] exp [4];
      int bad_data, bad_last, bad_gap;
      exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3; exp[3] = 8'hD4;
      for (int i = 0; i < 4; i++) mem[i] = exp[i];
      start_packet(4);
      collect(200, -1, 0);
      total_cnt++;
      if (got_data.size() != 4) $display("FAIL basic_count: got %0d bytes, required 4", got_data.size());
      else pass_cnt++;
      bad_data = 0; bad_last = 0; bad_gap = 0;
      for (int i = 0; i < got_data.size() && i < 4; i++) begin
         if (got_data[i] !== exp[i]) bad_data++;
         if (got_last[i] !== (i == 3)) bad_last++;
         if (i > 0 && got_cyc[i] - got_cyc[i-1] != 3) bad_gap++;
      end
      total_cnt++;
      if (bad_data != 0) $display("FAIL basic_data: %0d wrong bytes, required 0", bad_data);
      else pass_cnt++;
      total_cnt++;
      if (bad_last != 0) $display("FAIL basic_last: %0d wrong out_last flags, required 0", bad_last);
      else pass_cnt++;
      total_cnt++;
      if (bad_gap != 0) $display("FAIL basic_rate: %0d byte gaps not 3 cycles, required 0", bad_gap);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (pkt_count !== 16'd1) $display("FAIL basic_pkt: pkt_count=%0d required 1", pkt_count);
      else pass_cnt++;
      total_cnt++;
      if (buf_out_arm !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL basic_rearm: arm=%b valid=%b required arm=1 valid=0", buf_out_arm, out_valid);
      else pass_cnt++;
   endtask

   task automatic test_back_pressure();
      logic [7:0] exp [3];
      int bad;
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
      for (int i = 0; i < 3; i++) mem[i] = exp[i];
      start_packet(3);
      collect(200, 1, 5);
      total_cnt++;
      if (got_data.size() != 3) $display("FAIL stall_count: got %0d bytes, required 3", got_data.size());
      else pass_cnt++;
      bad = 0;
      for (int i = 0; i < got_data.size() && i < 3; i++)
         if (got_data[i] !== exp[i] || got_last[i] !== (i == 2)) bad++;
      total_cnt++;
      if (bad != 0) $display("FAIL stall_data: %0d wrong bytes, required 0", bad);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (pkt_count !== 16'd2) $display("FAIL stall_pkt: pkt_count=%0d required 2", pkt_count);
      else pass_cnt++;
   endtask

   task automatic test_zero_len();
      int n;
      bit saw_valid;
      start_packet(0);
      n = 0; saw_valid = 1'b0;
      while (buf_out_arm !== 1'b1 && n < 40) begin
         tick(); n++;
         if (out_valid === 1'b1) saw_valid = 1'b1;
      end
      total_cnt++;
      if (saw_valid) $display("FAIL zero_valid: out_valid seen 1, required 0");
      else pass_cnt++;
      total_cnt++;
      if (pkt_count !== 16'd3) $display("FAIL zero_pkt: pkt_count=%0d required 3", pkt_count);
      else pass_cnt++;
      total_cnt++;
      if (buf_out_arm !== 1'b1) $display("FAIL zero_rearm: buf_out_arm=%b required 1", buf_out_arm);
      else pass_cnt++;
   endtask

   task automatic test_clamp();
      int bad_data, bad_last;
      logic [8:0] idx;
      for (int i = 0; i < 512; i++) begin
         idx    = 9'(i);
         mem[i] = idx[7:0] ^ 8'h5A;
      end
      start_packet(600);
      collect(3000, -1, 0);
      total_cnt++;
      if (got_data.size() != 512) $display("FAIL clamp_count: got %0d bytes, required 512", got_data.size());
      else pass_cnt++;
      bad_data = 0; bad_last = 0;
      for (int i = 0; i < got_data.size() && i < 512; i++) begin
         if (got_data[i] !== mem[i]) bad_data++;
         if (got_last[i] !== (i == 511)) bad_last++;
      end
      total_cnt++;
      if (bad_data != 0 || bad_last != 0)
         $display("FAIL clamp_data: %0d wrong bytes, %0d wrong last flags, required 0", bad_data, bad_last);
      else pass_cnt++;
      total_cnt++;
      if (got_addr.size() != 512 || got_addr[got_addr.size()-1] !== 9'd511)
         $display("FAIL clamp_last_addr: %0d bytes, required last at address 511", got_addr.size());
      else pass_cnt++;
      tick();
      total_cnt++;
      if (pkt_count !== 16'd4) $display("FAIL clamp_pkt: pkt_count=%0d required 4", pkt_count);
      else pass_cnt++;
   endtask

   task automatic test_unconfigure();
      int n;
      for (int i = 0; i < 8; i++) mem[i] = 8'h80 + 8'(i);
      start_packet(8);
      out_ready = 1'b1;
      wait_valid("unconf_byte0");
      total_cnt++;
      if (out_data !== 8'h80) $display("FAIL unconf_byte0_data: out_data=%h required 80", out_data);
      else pass_cnt++;
      tick();
      out_ready = 1'b0;
      wait_valid("unconf_byte1");
      total_cnt++;
      if (out_data !== 8'h81) $display("FAIL unconf_byte1_data: out_data=%h required 81", out_data);
      else pass_cnt++;
      usb_configured = 1'b0;
      n = 0;
      while (out_valid !== 1'b0 && n < 10) begin tick(); n++; end
      total_cnt++;
      if (out_valid !== 1'b0 || n > 2)
         $display("FAIL unconf_drop: out_valid=%b after %0d cycles, required 0 within 2", out_valid, n);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (dut.state_q !== IDLE || out_valid !== 1'b0)
         $display("FAIL unconf_idle: state=%0d valid=%b required IDLE and 0", dut.state_q, out_valid);
      else pass_cnt++;
      total_cnt++;
      if (pkt_count !== 16'd4) $display("FAIL unconf_pkt: pkt_count=%0d required 4", pkt_count);
      else pass_cnt++;
      usb_configured = 1'b1;
   endtask

   task automatic test_reset_mid_packet();
      for (int i = 0; i < 4; i++) mem[i] = 8'h01 + 8'(i);
      start_packet(4);
      out_ready = 1'b1;
      wait_valid("rst_byte0");
      tick();
      out_ready = 1'b0;
      wait_valid("rst_byte1");
      reset = 1'b1;
      tick();
      total_cnt++;
      if ({buf_out_arm, out_valid, out_last} !== 3'b000)
         $display("FAIL midrst_ctrl: arm/valid/last=%b required 000", {buf_out_arm, out_valid, out_last});
      else pass_cnt++;
      total_cnt++;
      if (buf_out_addr !== 9'd0 || out_data !== 8'd0 || pkt_count !== 16'd0)
         $display("FAIL midrst_regs: addr=%h data=%h pkt=%h required 0", buf_out_addr, out_data, pkt_count);
      else pass_cnt++;
      reset = 1'b0;
      mem[0] = 8'h5A; mem[1] = 8'hA5;
      start_packet(2);
      collect(200, -1, 0);
      total_cnt++;
      if (got_data.size() != 2 || got_data[0] !== 8'h5A || got_data[1] !== 8'hA5 || got_last[1] !== 1'b1)
         $display("FAIL midrst_after: %0d bytes, required 5A A5 with last on second", got_data.size());
      else pass_cnt++;
      tick();
      total_cnt++;
      if (pkt_count !== 16'd1) $display("FAIL midrst_pkt: pkt_count=%0d required 1", pkt_count);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_pressure();
      test_zero_len();
      test_clamp();
      test_unconfigure();
      test_reset_mid_packet();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
